// File: rtl/seq_arith_unit.sv
// seq_arith_unit: multi-cycle add/sub/mul/div unit behind a valid/ready handshake.
// The divider datapath is built only when SAU_DIV_EN is defined; otherwise OP 1001 is illegal.
module seq_arith_unit #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     OP_code,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] Y,
    output logic           v,
    output logic           dz,
    output logic           err
);

    localparam int CW = $clog2(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
`ifdef SAU_DIV_EN
    localparam logic [1:0] S_DIV  = 2'd2;
`endif
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_ADD = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
`ifdef SAU_DIV_EN
    localparam logic [3:0] OP_DIV = 4'b1001;
`endif

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] y_q, y_d;
    logic [W-1:0]   opnd_q, opnd_d;
    logic           v_q, v_d;
    logic           dz_q, dz_d;
    logic           err_q, err_d;

    logic           is_add, is_sub, is_mul;
    logic [W-1:0]   sum, diff;
    logic [W:0]     hsum;

    assign is_add = (OP_code == OP_ADD);
    assign is_sub = (OP_code == OP_SUB);
    assign is_mul = (OP_code == OP_MUL);
    assign sum    = A + B;
    assign diff   = A - B;

    // Shift-add: y_q holds {partial, multiplier}; add multiplicand into the top half.
    assign hsum = {1'b0, y_q[2*W-1:W]} + (y_q[0] ? {1'b0, opnd_q} : '0);

`ifdef SAU_DIV_EN
    logic           is_div;
    logic [W:0]     dsh;
    logic [W-1:0]   dtrial;
    logic           dge;

    assign is_div = (OP_code == OP_DIV);
    // Restoring step: y_q holds {remainder, dividend/quotient}.
    assign dsh    = y_q[2*W-1:W-1];
    assign dge    = (dsh >= {1'b0, opnd_q});
    assign dtrial = dsh[W-1:0] - opnd_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        opnd_d  = opnd_q;
        v_d     = v_q;
        dz_d    = dz_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_DONE;
                    cnt_d   = CW'(W - 1);
                    opnd_d  = A;
                    y_d     = '0;
                    v_d     = 1'b0;
                    dz_d    = 1'b0;
                    err_d   = 1'b0;
                    unique case (1'b1)
                        is_add: begin
                            y_d = {{W{sum[W-1]}}, sum};
                            v_d = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
                        end
                        is_sub: begin
                            y_d = {{W{diff[W-1]}}, diff};
                            v_d = (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]);
                        end
                        is_mul: begin
                            state_d = S_MUL;
                            y_d     = {{W{1'b0}}, B};
                        end
`ifdef SAU_DIV_EN
                        is_div: begin
                            if (B == '0) begin
                                y_d  = {A, {W{1'b1}}};
                                dz_d = 1'b1;
                            end else begin
                                state_d = S_DIV;
                                y_d     = {{W{1'b0}}, A};
                                opnd_d  = B;
                            end
                        end
`endif
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_MUL: begin
                y_d = {hsum, y_q[W-1:1]};
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
`ifdef SAU_DIV_EN
            S_DIV: begin
                y_d = dge ? {dtrial, y_q[W-2:0], 1'b1}
                          : {dsh[W-1:0], y_q[W-2:0], 1'b0};
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
`endif
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            opnd_q  <= '0;
            v_q     <= 1'b0;
            dz_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            opnd_q  <= opnd_d;
            v_q     <= v_d;
            dz_q    <= dz_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign Y         = y_q;
    assign v         = v_q;
    assign dz        = dz_q;
    assign err       = err_q;

endmodule

// File: doc/seq_arith_unit.md
# seq_arith_unit

Parametrised, multi-cycle successor to the 4-bit combinational arithmetic unit. It performs add, subtract, multiply and divide on W-bit operands behind a valid/ready handshake. Multiply and divide are computed iteratively: one shift-add or restore step per clock. Sits between the opcode decoder and the result writeback path of the ALU.

## Interface
- W, 4: operand width in bits, W ≥ 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request.
- OP_code  in  4  operation code:
  - 4'b0110 add
  - 4'b0111 sub
  - 4'b1000 mul
  - 4'b1001 div
  - any other value is illegal.
- A  in  W  first operand.
- B  in  W  second operand.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- Y  out  2W  result.
- v  out  1  signed overflow (add/sub only).
- dz  out  1  divide by zero.
- err  out  1  illegal opcode.

## Operation
- States: IDLE, MUL, DIV, DONE.
- in_ready = (state == IDLE).
- Accept when in_valid & in_ready. On the accept edge, A, B and OP_code are latched.
- Transitions out of IDLE on accept:
  - add/sub → DONE.
  - mul → MUL.
  - div with B≠0 → DIV.
  - div with B=0 → DONE.
  - illegal opcode → DONE.
  - no accept → stay in IDLE.
- Add/sub:
  - Operands are two's-complement. Result is the W-bit sum or difference, sign-extended to 2W.
  - Add: v=1 iff A[W-1]==B[W-1] and sum[W-1]≠A[W-1].
  - Sub: v=1 iff A[W-1]≠B[W-1] and diff[W-1]≠A[W-1].
- Mul:
  - Unsigned, shift-add, one partial product per cycle, W step cycles.
  - Y = A*B, full 2W bits. v=0.
- Div:
  - Unsigned restoring division, one quotient bit per cycle, W step cycles.
  - Y = {remainder, quotient}, each W bits.
- Div by zero: Y = {A, {W{1'b1}}}, dz=1, no iteration.
- Illegal opcode: Y=0, err=1.
- Flags not applicable to the current operation are driven 0.
- A step counter counts W-1 down to 0. The transition MUL/DIV → DONE occurs on the edge where the counter is 0.
- DONE:
  - out_valid=1. Y and the flags hold stable until out_ready.
  - On the edge where out_valid & out_ready, go to IDLE.
- Operand inputs are ignored outside the accept edge; changes mid-operation have no effect.

## Timing
- Reset (async assert, sync release): state=IDLE, counter=0, Y=0, v=0, dz=0, err=0, out_valid=0, in_ready=1.
- Latency, accept edge k → out_valid high:
  - add/sub, div-by-zero, illegal opcode: after edge k (1 cycle).
  - mul/div: after edge k+W (W+1 cycles).
- Throughput:
  - in_ready is low from the cycle after accept until the cycle after the output handshake.
  - With out_ready tied high: add/sub issue every 2 cycles; mul/div every W+2 cycles.
- Back-pressure: out_ready low holds DONE indefinitely; outputs do not change.
- Reset asserted mid-MUL/DIV: operation aborted immediately, outputs take reset values, no result is ever presented.
- in_valid while busy: ignored, not queued. The requester must hold it until in_ready.
- All outputs are registered; no combinational path from inputs to outputs except none (in_ready is decoded from state).

## Configuration
- SAU_DIV_EN:
  - Defined: the divider datapath and DIV state are built; behaviour is as above.
  - Undefined: no divider hardware is built. OP_code 4'b1001 is treated as an illegal opcode (Y=0, err=1, 1-cycle latency), and dz is tied 0.

## Test plan
All with W=4, out_ready=1 unless noted.
- Add overflow: A=4'h7, B=4'h1, add → after 1 cycle Y=8'hF8, v=1, dz=0, err=0.
- Sub overflow: A=4'h8, B=4'h1, sub → Y=8'h07, v=1. Also A=4'h3, B=4'h5 → Y=8'hFE, v=0.
- Mul with back-pressure: A=4'hF, B=4'hF, mul → out_valid asserted exactly 5 cycles after accept, Y=8'hE1. With out_ready held low for 3 cycles, Y stays 8'hE1 and in_ready stays 0.
- Div: A=4'hD, B=4'h4 → after 5 cycles Y=8'h13 (remainder 1, quotient 3). Divide by zero, A=4'h9, B=4'h0 → after 1 cycle Y=8'h9F, dz=1.
- Illegal opcode and macro: OP_code=4'b0000 → Y=0, err=1. With SAU_DIV_EN undefined, OP_code=4'b1001 → Y=0, err=1, dz=0.
- Reset mid-operation: start a mul, assert rst_n=0 two cycles after accept → out_valid=0, in_ready=1 immediately. After release, a new add 2+3 yields Y=8'h05.
